// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory. Port 0 has fixed
// priority; port 1 is forced through after STARVE_LIMIT consecutive lost conflicts.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_mask,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_mask,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_sdata,
  output logic [3:0]  mem_mask,
  output logic        mem_lenable,
  input  logic [31:0] mem_ldata
);
  localparam int NP = 2;

  logic [NP-1:0]       req, gnt, is_rd, rvalid;
  logic [NP-1:0][31:0] addr, wdata;
  logic [NP-1:0][3:0]  mask;
  logic [7:0]          starve_cnt;
  logic                starved, rsel_valid, rsel_port;

  assign req   = {p1_req, p0_req};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};
  assign mask  = {p1_mask, p0_mask};

  assign starved = (starve_cnt >= 8'(STARVE_LIMIT));
  // Grants are masked by rst so nothing reaches the memory while held in reset.
  assign gnt[0]  = rst & req[0] & ~(req[1] & starved);
  assign gnt[1]  = rst & req[1] & ~gnt[0];

  for (genvar i = 0; i < NP; i++) begin : g_port
    assign is_rd[i]  = (mask[i] == 4'b0000);
    // A read granted just before reset asserts is dropped, not delivered late.
    assign rvalid[i] = rst & rsel_valid & (rsel_port == 1'(i));
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = mem_ldata;
  assign p1_rdata  = mem_ldata;

  always_comb begin
    mem_addr    = '0;
    mem_sdata   = '0;
    mem_mask    = '0;
    mem_lenable = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (gnt[i]) begin
        mem_addr    = addr[i];
        mem_sdata   = wdata[i];
        mem_mask    = mask[i];
        mem_lenable = is_rd[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      rsel_valid <= 1'b0;
      rsel_port  <= 1'b0;
    end else begin
      if (req[1] && !gnt[1]) begin
        if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= '0;
      end
      rsel_valid <= |(gnt & is_rd);
      rsel_port  <= gnt[1];
    end
  end

endmodule
